// File: rtl/mmio_resp_pkg.sv
// Shared definitions for the AXI-Lite MMIO responder: register indices
// (addr[5:2]), AXI response codes, IRQ bit positions and FSM state types.
package mmio_resp_pkg;

    localparam logic [3:0] REG_ID       = 4'h0;
    localparam logic [3:0] REG_SCRATCH  = 4'h1;
    localparam logic [3:0] REG_TXDATA   = 4'h2;
    localparam logic [3:0] REG_STATUS   = 4'h3;
    localparam logic [3:0] REG_IRQ_EN   = 4'h4;
    localparam logic [3:0] REG_IRQ_PEND = 4'h5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int IRQ_EMPTY_BIT = 0;
    localparam int IRQ_OVF_BIT   = 1;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // Mapped registers occupy the contiguous index range ID..IRQ_PEND.
    function automatic logic reg_mapped(input logic [3:0] idx);
        return idx <= REG_IRQ_PEND;
    endfunction

endpackage

// File: rtl/mmio_byte_fifo.sv
// Synchronous byte FIFO with occupancy level. Push while full is ignored
// (the caller sees it via `full`). `drain_evt` pulses on the cycle a pop
// takes the level from 1 to 0.
module mmio_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drain_evt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head      = mem_q[rd_ptr_q];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign drain_evt = (level_q == ONE_LVL) && pop_ok && !push_ok;

    // Pointer and level bookkeeping; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    // Storage is not reset; emptiness is tracked by the level alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/axilite_mmio_responder.sv
// AXI4-Lite MMIO responder: ID/scratch/status/IRQ registers plus a byte TX
// FIFO drained over tx_valid/tx_ready, with a registered level interrupt.
// Build option MMIO_TXFIFO_OVF_ERR_EN: a TXDATA write while the FIFO is full
// answers SLVERR instead of OKAY (the overflow pend bit is set either way).
module axilite_mmio_responder
    import mmio_resp_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4D4D_0001
) (
    input  logic                    uncoreclk,
    input  logic                    uncorerst,
    input  logic [ADDR_WIDTH-1:0]   S_AXILITE_MMIO_awaddr,
    input  logic [2:0]              S_AXILITE_MMIO_awprot,
    input  logic                    S_AXILITE_MMIO_awvalid,
    output logic                    S_AXILITE_MMIO_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXILITE_MMIO_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXILITE_MMIO_wstrb,
    input  logic                    S_AXILITE_MMIO_wvalid,
    output logic                    S_AXILITE_MMIO_wready,
    output logic [1:0]              S_AXILITE_MMIO_bresp,
    output logic                    S_AXILITE_MMIO_bvalid,
    input  logic                    S_AXILITE_MMIO_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXILITE_MMIO_araddr,
    input  logic [2:0]              S_AXILITE_MMIO_arprot,
    input  logic                    S_AXILITE_MMIO_arvalid,
    output logic                    S_AXILITE_MMIO_arready,
    output logic [DATA_WIDTH-1:0]   S_AXILITE_MMIO_rdata,
    output logic [1:0]              S_AXILITE_MMIO_rresp,
    output logic                    S_AXILITE_MMIO_rvalid,
    input  logic                    S_AXILITE_MMIO_rready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    irq
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    // Write channel latches and response FSM
    logic                  aw_held_q, aw_held_d, awready_q, awready_d;
    logic [3:0]            awidx_q, awidx_d;
    logic                  w_held_q, w_held_d, wready_q, wready_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    wr_state_e             w_state_q, w_state_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // Read FSM
    rd_state_e             r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Registers
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [1:0]            irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
    logic                  irq_q, irq_d;

    // Datapath helpers
    logic                  aw_hs, w_hs, wr_exec, ar_hs;
    logic [3:0]            wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  fifo_push, fifo_full, fifo_empty, fifo_drain, overflow;
    logic [LVL_W-1:0]      fifo_level;
    logic [DATA_WIDTH-1:0] status_word, rd_value;
    logic [1:0]            pend_clr;
    logic                  unused_bits;

    assign unused_bits = ^{S_AXILITE_MMIO_awprot, S_AXILITE_MMIO_arprot,
                           S_AXILITE_MMIO_awaddr[ADDR_WIDTH-1:6], S_AXILITE_MMIO_awaddr[1:0],
                           S_AXILITE_MMIO_araddr[ADDR_WIDTH-1:6], S_AXILITE_MMIO_araddr[1:0]};

    assign aw_hs  = S_AXILITE_MMIO_awvalid && awready_q;
    assign w_hs   = S_AXILITE_MMIO_wvalid && wready_q;
    assign ar_hs  = S_AXILITE_MMIO_arvalid && arready_q;
    assign rd_idx = S_AXILITE_MMIO_araddr[5:2];

    // A channel accepted this cycle counts as held, so AW+W together execute
    // immediately and bvalid follows one cycle later.
    assign wr_idx  = aw_held_q ? awidx_q : S_AXILITE_MMIO_awaddr[5:2];
    assign wr_data = w_held_q  ? wdata_q : S_AXILITE_MMIO_wdata;
    assign wr_strb = w_held_q  ? wstrb_q : S_AXILITE_MMIO_wstrb;
    assign wr_exec = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (w_state_q == W_IDLE);

    assign fifo_push = wr_exec && (wr_idx == REG_TXDATA) && wr_strb[0];
    assign overflow  = fifo_push && fifo_full;

    mmio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (uncoreclk),
        .rst       (uncorerst),
        .push      (fifo_push),
        .push_data (wr_data[7:0]),
        .pop       (tx_valid && tx_ready),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .drain_evt (fifo_drain)
    );

    assign tx_valid = !fifo_empty;

    // Write channel capture, register updates and B response sequencing.
    always_comb begin
        aw_held_d  = aw_held_q;
        awidx_d    = aw_hs ? S_AXILITE_MMIO_awaddr[5:2] : awidx_q;
        w_held_d   = w_held_q;
        wdata_d    = w_hs ? S_AXILITE_MMIO_wdata : wdata_q;
        wstrb_d    = w_hs ? S_AXILITE_MMIO_wstrb : wstrb_q;
        w_state_d  = w_state_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        scratch_d  = scratch_q;
        irq_en_d   = irq_en_q;
        pend_clr   = 2'b00;

        if (wr_exec) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs)  w_held_d  = 1'b1;
        end

        case (w_state_q)
            W_IDLE: if (wr_exec) begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
                bresp_d   = reg_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
`ifdef MMIO_TXFIFO_OVF_ERR_EN
                if (overflow) bresp_d = RESP_SLVERR;
`endif
            end
            W_RESP: if (S_AXILITE_MMIO_bready) begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
            end
            default: w_state_d = W_IDLE;
        endcase

        if (wr_exec) begin
            case (wr_idx)
                REG_SCRATCH:
                    for (int b = 0; b < STRB_W; b++)
                        if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                REG_IRQ_EN:   if (wr_strb[0]) irq_en_d = wr_data[1:0];
                REG_IRQ_PEND: if (wr_strb[0]) pend_clr = wr_data[1:0];
                default: ;
            endcase
        end

        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
    end

    // Pending bits: hardware set wins over a simultaneous W1C.
    always_comb begin
        irq_pend_d = irq_pend_q & ~pend_clr;
        if (fifo_drain) irq_pend_d[IRQ_EMPTY_BIT] = 1'b1;
        if (overflow)   irq_pend_d[IRQ_OVF_BIT]   = 1'b1;
        irq_d = |(irq_pend_q & irq_en_q);
    end

    // Read decode and R channel sequencing. For FIFO_DEPTH=256 the level MSB
    // lands in bit 16 of STATUS.
    always_comb begin
        status_word = '0;
        status_word[0] = fifo_full;
        status_word[1] = fifo_empty;
        status_word[8 +: LVL_W] = fifo_level;

        rd_value = '0;
        case (rd_idx)
            REG_ID:       rd_value = ID_VALUE;
            REG_SCRATCH:  rd_value = scratch_q;
            REG_STATUS:   rd_value = status_word;
            REG_IRQ_EN:   rd_value[1:0] = irq_en_q;
            REG_IRQ_PEND: rd_value[1:0] = irq_pend_q;
            default: ;
        endcase

        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_value;
                    rresp_d   = reg_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: if (S_AXILITE_MMIO_rready) begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // All control and register state; reset abandons any in-flight transfer.
    always_ff @(posedge uncoreclk or posedge uncorerst) begin
        if (uncorerst) begin
            aw_held_q  <= 1'b0;
            awready_q  <= 1'b0;
            awidx_q    <= '0;
            w_held_q   <= 1'b0;
            wready_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            w_state_q  <= W_IDLE;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            scratch_q  <= '0;
            irq_en_q   <= '0;
            irq_pend_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            aw_held_q  <= aw_held_d;
            awready_q  <= awready_d;
            awidx_q    <= awidx_d;
            w_held_q   <= w_held_d;
            wready_q   <= wready_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            w_state_q  <= w_state_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            scratch_q  <= scratch_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_d;
        end
    end

    assign S_AXILITE_MMIO_awready = awready_q;
    assign S_AXILITE_MMIO_wready  = wready_q;
    assign S_AXILITE_MMIO_bvalid  = bvalid_q;
    assign S_AXILITE_MMIO_bresp   = bresp_q;
    assign S_AXILITE_MMIO_arready = arready_q;
    assign S_AXILITE_MMIO_rvalid  = rvalid_q;
    assign S_AXILITE_MMIO_rdata   = rdata_q;
    assign S_AXILITE_MMIO_rresp   = rresp_q;
    assign irq                    = irq_q;

endmodule

// File: tb/tb_axilite_mmio_responder.sv
// Self-checking bench for axilite_mmio_responder: directed vector table,
// hand-timed corner sequences, and randomized traffic against a
// transaction-level model (register values, byte queue, pend/enable bits).
module tb_axilite_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, irq;

    int checks = 0;
    int errors = 0;

`ifdef MMIO_TXFIFO_OVF_ERR_EN
    localparam logic [1:0] OVF_RESP = 2'b10;
`else
    localparam logic [1:0] OVF_RESP = 2'b00;
`endif

    axilite_mmio_responder dut (
        .uncoreclk              (clk),
        .uncorerst              (rst),
        .S_AXILITE_MMIO_awaddr  (awaddr),
        .S_AXILITE_MMIO_awprot  (awprot),
        .S_AXILITE_MMIO_awvalid (awvalid),
        .S_AXILITE_MMIO_awready (awready),
        .S_AXILITE_MMIO_wdata   (wdata),
        .S_AXILITE_MMIO_wstrb   (wstrb),
        .S_AXILITE_MMIO_wvalid  (wvalid),
        .S_AXILITE_MMIO_wready  (wready),
        .S_AXILITE_MMIO_bresp   (bresp),
        .S_AXILITE_MMIO_bvalid  (bvalid),
        .S_AXILITE_MMIO_bready  (bready),
        .S_AXILITE_MMIO_araddr  (araddr),
        .S_AXILITE_MMIO_arprot  (arprot),
        .S_AXILITE_MMIO_arvalid (arvalid),
        .S_AXILITE_MMIO_arready (arready),
        .S_AXILITE_MMIO_rdata   (rdata),
        .S_AXILITE_MMIO_rresp   (rresp),
        .S_AXILITE_MMIO_rvalid  (rvalid),
        .S_AXILITE_MMIO_rready  (rready),
        .tx_data                (tx_data),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .irq                    (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_scr;
    logic [1:0]  m_en, m_pend;
    logic [7:0]  m_q[$];

    function automatic void m_reset();
        m_scr = 32'h0; m_en = 2'b00; m_pend = 2'b00; m_q.delete();
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output logic [1:0] resp);
        int lvl;
        lvl = m_q.size();
        resp = 2'b00;
        case (a[5:2])
            4'd0: return 32'h4D4D_0001;
            4'd1: return m_scr;
            4'd2: return 32'h0;
            4'd3: return {16'h0, 8'(lvl), 6'h0, (lvl == 0), (lvl == 16)};
            4'd4: return {30'h0, m_en};
            4'd5: return {30'h0, m_pend};
            default: begin resp = 2'b10; return 32'h0; end
        endcase
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] resp;
        resp = 2'b00;
        case (a[5:2])
            4'd1: for (int b = 0; b < 4; b++) if (s[b]) m_scr[8*b +: 8] = d[8*b +: 8];
            4'd2: if (s[0]) begin
                if (m_q.size() == 16) begin m_pend[1] = 1'b1; resp = OVF_RESP; end
                else m_q.push_back(d[7:0]);
            end
            4'd4: if (s[0]) m_en = d[1:0];
            4'd5: if (s[0]) m_pend = m_pend & ~d[1:0];
            4'd0, 4'd3: ;
            default: resp = 2'b10;
        endcase
        return resp;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic cyc();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, a_now, w_now;
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            a_now = awvalid && awready;
            w_now = wvalid && wready;
            cyc();
            if (a_now) begin aw_done = 1; awvalid = 1'b0; end
            if (w_now) begin w_done = 1; wvalid = 1'b0; end
            n++;
        end
        if (!(aw_done && w_done)) begin timeout("wr_accept"); awvalid = 1'b0; wvalid = 1'b0; end
        n = 0;
        while (!bvalid && n < 50) begin cyc(); n++; end
        if (!bvalid) timeout("wr_bvalid");
        resp = bresp;
        cyc();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit acc;
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 50) begin
            acc = arready;
            cyc();
            n++;
        end
        arvalid = 1'b0;
        if (!acc) timeout("rd_accept");
        check("rd_latency_rvalid", rvalid, 1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        check("rd_rvalid_drop", rvalid, 0);
    endtask

    task automatic wr_chk(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r, e;
        e = m_write(a, d, s);
        axi_write(a, d, s, r);
        check({name, "_bresp"}, r, e);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a);
        logic [31:0] d, e;
        logic [1:0]  r, er;
        e = m_read(a, er);
        axi_read(a, d, r);
        check({name, "_rdata"}, d, e);
        check({name, "_rresp"}, r, er);
    endtask

    // Drain the byte queue through tx_ready, comparing each popped byte.
    task automatic drain();
        int n;
        bit had;
        had = (m_q.size() != 0);
        @(negedge clk);
        tx_ready = 1'b1;
        n = 0;
        while (m_q.size() != 0 && n < 300) begin
            check("drain_valid", tx_valid, 1);
            check("drain_data", tx_data, m_q.pop_front());
            cyc();
            n++;
        end
        tx_ready = 1'b0;
        if (had) m_pend[0] = 1'b1;
        check("drain_empty", tx_valid, 0);
        cyc();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        logic [1:0]  r;
        int          n;

        rst = 1'b1;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0; tx_ready = 0;
        m_reset();
        repeat (3) cyc();

        // Reset state
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        repeat (2) cyc();

        // W first, AW three cycles later; bvalid must wait for AW and then
        // follow it by exactly one cycle.
        wdata = 32'hA5A5_1234; wstrb = 4'b0011; wvalid = 1'b1;
        check("wfirst_wready", wready, 1);
        cyc();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("wfirst_no_bvalid", bvalid, 0);
            check("wfirst_wready_low", wready, 0);
            cyc();
        end
        awaddr = 32'h04; awvalid = 1'b1;
        check("wfirst_awready", awready, 1);
        check("wfirst_no_bvalid_aw", bvalid, 0);
        cyc();
        awvalid = 1'b0;
        check("wfirst_bvalid", bvalid, 1);
        check("wfirst_bresp", bresp, 2'b00);
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        check("wfirst_bvalid_drop", bvalid, 0);
        check("wfirst_wready_back", wready, 1);
        void'(m_write(32'h04, 32'hA5A5_1234, 4'b0011));

        vecs[0]  = '{0, 32'h00, 0, 0, 2'b00, 32'h4D4D_0001};
        vecs[1]  = '{0, 32'h04, 0, 0, 2'b00, 32'h0000_1234};
        vecs[2]  = '{0, 32'h0C, 0, 0, 2'b00, 32'h0000_0002};
        vecs[3]  = '{1, 32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 0};
        vecs[4]  = '{0, 32'h04, 0, 0, 2'b00, 32'hDEAD_BEEF};
        vecs[5]  = '{1, 32'h04, 32'h1234_5678, 4'b0100, 2'b00, 0};
        vecs[6]  = '{0, 32'h04, 0, 0, 2'b00, 32'hDE34_BEEF};
        vecs[7]  = '{0, 32'h08, 0, 0, 2'b00, 32'h0};
        vecs[8]  = '{0, 32'h3C, 0, 0, 2'b10, 32'h0};
        vecs[9]  = '{1, 32'h20, 32'hFFFF_FFFF, 4'hF, 2'b10, 0};
        vecs[10] = '{0, 32'h04, 0, 0, 2'b00, 32'hDE34_BEEF};
        vecs[11] = '{1, 32'h10, 32'h3, 4'h1, 2'b00, 0};
        vecs[12] = '{0, 32'h10, 0, 0, 2'b00, 32'h3};
        vecs[13] = '{1, 32'h10, 32'h0, 4'h1, 2'b00, 0};
        vecs[14] = '{0, 32'h14, 0, 0, 2'b00, 32'h0};
        vecs[15] = '{0, 32'h40, 0, 0, 2'b00, 32'h4D4D_0001};

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                void'(m_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
                check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
            end
        end

        // Three pushes, STATUS, then drain with exact irq timing.
        wr_chk("en1", 32'h10, 32'h1, 4'h1);
        wr_chk("push41", 32'h08, 32'h41, 4'h1);
        wr_chk("push42", 32'h08, 32'h42, 4'h1);
        wr_chk("push43", 32'h08, 32'h43, 4'h1);
        axi_read(32'h0C, d, r);
        check("status3", d, 32'h0000_0300);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("seq_valid", tx_valid, 1);
            check("seq_data", tx_data, 32'h41 + i);
            cyc();
        end
        check("seq_empty", tx_valid, 0);
        check("seq_irq_not_yet", irq, 0);
        cyc();
        check("seq_irq_rise", irq, 1);
        tx_ready = 1'b0;
        m_q.delete();
        m_pend[0] = 1'b1;
        rd_chk("pend_empty", 32'h14);
        wr_chk("w1c_empty", 32'h14, 32'h1, 4'h1);
        check("irq_fall_empty", irq, 0);

        // Fill to 16, overflow push, then clear both pend bits.
        for (int i = 0; i < 16; i++) wr_chk("fill", 32'h08, 32'(i * 3 + 7), 4'h1);
        axi_read(32'h0C, d, r);
        check("status_full", d, 32'h0000_1001);
        axi_write(32'h08, 32'hFF, 4'h1, r);
        check("ovf_bresp", r, OVF_RESP);
        void'(m_write(32'h08, 32'hFF, 4'h1));
        axi_read(32'h14, d, r);
        check("ovf_pend", d, 32'h2);
        check("ovf_irq_masked", irq, 0);
        wr_chk("en3", 32'h10, 32'h3, 4'h1);
        check("ovf_irq", irq, 1);
        wr_chk("w1c_all", 32'h14, 32'h3, 4'h1);
        check("irq_fall_ovf", irq, 0);
        rd_chk("pend_clear", 32'h14);
        drain();
        check("irq_after_drain", irq, 1);
        wr_chk("w1c_drain", 32'h14, 32'h1, 4'h1);

        // R channel held off: data/resp stable, arready low.
        @(negedge clk);
        araddr = 32'h00; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin cyc(); n++; end
        if (!arready) timeout("hold_accept");
        cyc();
        arvalid = 1'b0;
        araddr = 32'h04;
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata", rdata, 32'h4D4D_0001);
            check("hold_rresp", rresp, 2'b00);
            check("hold_arready", arready, 0);
            cyc();
        end
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        check("hold_release", rvalid, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 250; it++) begin
            logic [31:0] a, v;
            logic [3:0]  s;
            int op;
            op = $urandom_range(0, 9);
            v  = $urandom;
            s  = 4'($urandom_range(0, 15));
            a  = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            case (op)
                0, 1: rd_chk("rnd_rd", a);
                2, 3: wr_chk("rnd_scr", 32'h04, v, s);
                4, 5: wr_chk("rnd_tx", 32'h08, v, ($urandom_range(0, 3) == 0) ? s : 4'h1);
                6:    wr_chk("rnd_en", 32'h10, v, s);
                7:    wr_chk("rnd_w1c", 32'h14, v, s);
                8:    if ($urandom_range(0, 1) == 1) drain(); else rd_chk("rnd_status", 32'h0C);
                default: wr_chk("rnd_any", a, v, s);
            endcase
            check("rnd_irq", irq, 32'(|(m_pend & m_en)));
        end

        // Reset in the middle of a write with bvalid pending and five bytes queued.
        drain();
        for (int i = 0; i < 5; i++) wr_chk("pre_rst_push", 32'h08, 32'h60 + i, 4'h1);
        wr_chk("pre_rst_scr", 32'h04, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin
            cyc();
            if (!awready) awvalid = 1'b0;
            if (!wready)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!bvalid) timeout("pre_rst_bvalid");
        rst = 1'b1;
        #1;
        check("midrst_bvalid", bvalid, 0);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_irq", irq, 0);
        check("midrst_awready", awready, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cyc();
        rd_chk("post_rst_status", 32'h0C);
        rd_chk("post_rst_scr", 32'h04);
        rd_chk("post_rst_pend", 32'h14);
        rd_chk("post_rst_en", 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
